mem_write_checker: RTL
======================

Name: mem_write_checker

Overview:
- Synthesizable, parametrised bus-write checker that sits beside the computer's data-memory port (memWrite/dataAddr/writeData).
- Holds a table of DEPTH expected (address, data) writes, loaded before a run, and tracks matches in ordered or any-order mode.
- Enforces a cycle timeout and reports registered done/pass/fail with an error code.
- Replaces single hard-coded address/data checks in benches; also usable as an on-chip self-test monitor.

Parameters:
- N, 32, data width of writeData / exp_data
- A, 32, address width of dataAddr / exp_addr
- DEPTH, 4, number of expected-write entries (>=1)
- TIMEOUT, 1024, max cycles in RUN before failing (>=2)
- ORDERED, 1, 1 = writes must match entries in index order; 0 = any order

Ports:
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state including the table
- exp_we  in  1  load strobe for one table entry (honoured only in IDLE/PASS/FAIL)
- exp_idx  in  $clog2(DEPTH)  entry index to load
- exp_addr  in  A  expected address
- exp_data  in  N  expected data
- exp_clr  in  1  clears all entry valid bits (not honoured in RUN)
- start  in  1  begin a run
- memWrite  in  1  monitored write enable
- dataAddr  in  A  monitored address
- writeData  in  N  monitored data
- done  out  1  high in PASS or FAIL
- pass  out  1  high in PASS
- fail  out  1  high in FAIL
- err_code  out  2  00 none, 01 data mismatch, 10 timeout
- match_count  out  $clog2(DEPTH+1)  entries matched this run
- cycle_count  out  $clog2(TIMEOUT+1)  cycles spent in current/last run

Behaviour:
- Reset (async) values:
  - state = IDLE
  - all valid/matched bits 0; table contents 0
  - done = pass = fail = 0; err_code = 0; match_count = 0; cycle_count = 0
- States: IDLE, RUN, PASS, FAIL. All outputs are registered.
- Loading:
  - exp_we writes addr/data and sets valid[exp_idx]; exp_idx >= DEPTH is ignored.
  - exp_clr clears all valid bits. exp_clr and exp_we in the same cycle: clear first, then the load takes effect.
- start (in IDLE/PASS/FAIL):
  - next state RUN; matched bits, match_count, cycle_count, err_code cleared; done/pass/fail drop on that edge.
  - If no entry is valid, next state is PASS directly, with cycle_count = 0.
  - start in RUN is ignored.
- RUN:
  - cycle_count increments every cycle.
  - memWrite is sampled each posedge.
  - No write in a cycle has no effect on matching.
- ORDERED = 1:
  - ptr = lowest valid unmatched index.
  - Write with addr == entry[ptr].addr and data == entry[ptr].data: set matched, match_count++.
  - Write with addr == entry[ptr].addr and differing data: FAIL, err_code = 01.
  - Write to any other address: ignored (stray writes allowed).
- ORDERED = 0:
  - The lowest-index valid unmatched entry matching both addr and data is marked matched.
  - If none matches both, but some valid unmatched entry matches addr: FAIL, err_code = 01.
  - Otherwise ignored.
- A single write marks at most one entry. Duplicate entries need duplicate writes.
- When all valid entries are matched, the next state is PASS; done and pass assert on the same edge the last match registers.
- Timeout: if cycle_count == TIMEOUT-1 and the run is not complete, next state is FAIL, err_code = 10.
- Same-cycle conflicts:
  - Last match coincident with timeout: PASS wins.
  - Data mismatch coincident with timeout: err_code = 01.
- PASS/FAIL: hold all outputs until start or reset. Monitor inputs are ignored.
- Reset asserted mid-run: immediate return to IDLE; the table is lost and must be reloaded.

Test Plan:
- Load entry0 = (84, 0x96), start, write (84, 0x96) at cycle 5 -> pass = 1 and done = 1 on that edge, match_count = 1, err_code = 00, cycle_count = 5.
- ORDERED = 1, entries (80, 0x7), (84, 0x96); writes (84, 0x96) then (80, 0x7) then (84, 0x96):
  - first write ignored, match_count 0 -> 1 -> 2, PASS after the third write.
- ORDERED = 0, same entries, writes (84, 0x96), (80, 0x7) -> PASS after the second write, match_count = 2.
- Entry (84, 0x96), write (84, 0x95) -> FAIL next edge, err_code = 01; a stray write (100, 0x1) beforehand has no effect.
- TIMEOUT = 8, entry loaded, no writes -> FAIL with err_code = 10 and cycle_count = 7. Variant: last match at cycle_count = 7 -> PASS.
- Reset mid-run and start with an empty table:
  - Async reset pulse mid-run -> all outputs 0 immediately.
  - After exp_clr then start -> PASS on the next edge with match_count = 0.

Source files
------------

// File: rtl/mem_write_checker.sv
// Bus-write checker: compares monitored data-memory writes against a loaded table of
// expected (address, data) pairs, in ordered or any-order mode, with a cycle timeout.
module mem_write_checker #(
  parameter int N       = 32,
  parameter int A       = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024,
  parameter int ORDERED = 1,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int MC_W   = $clog2(DEPTH + 1),
  localparam int CC_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_idx,
  input  logic [A-1:0]     exp_addr,
  input  logic [N-1:0]     exp_data,
  input  logic             exp_clr,
  input  logic             start,
  input  logic             memWrite,
  input  logic [A-1:0]     dataAddr,
  input  logic [N-1:0]     writeData,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [1:0]       err_code,
  output logic [MC_W-1:0]  match_count,
  output logic [CC_W-1:0]  cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_e;
  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_DATA    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  state_e            state_q, state_d;
  logic [A-1:0]      addr_q [DEPTH];
  logic [N-1:0]      data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  matched_q, matched_d;
  logic              done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  err_e              err_q, err_d;
  logic [MC_W-1:0]   match_cnt_q, match_cnt_d;
  logic [CC_W-1:0]   cycle_cnt_q, cycle_cnt_d;

  logic              run, idx_ok, load_en;
  logic [DEPTH-1:0]  hit_oh, matched_hit;
  logic              addr_hit, ptr_found, wr_hit, wr_bad, all_matched, timed_out;

  assign run     = (state_q == S_RUN);
  assign idx_ok  = (32'(exp_idx) < DEPTH);
  assign load_en = !run && exp_we && idx_ok;

  // Clear happens before the load, so a same-cycle clear+load leaves exactly one entry valid.
  always_comb begin
    valid_d = valid_q;
    if (!run) begin
      if (exp_clr) valid_d = '0;
      if (load_en) valid_d[exp_idx] = 1'b1;
    end
  end

  // NOTE: blocking assignments here are intentional -- later loop iterations must see
  // the flags set by earlier ones to pick the lowest matching index.
  always_comb begin
    hit_oh    = '0;
    addr_hit  = 1'b0;
    ptr_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && !matched_q[i]) begin
        if (ORDERED != 0) begin
          if (!ptr_found) begin
            ptr_found = 1'b1;
            if (dataAddr == addr_q[i]) begin
              addr_hit = 1'b1;
              if (writeData == data_q[i]) hit_oh[i] = 1'b1;
            end
          end
        end else if (dataAddr == addr_q[i]) begin
          addr_hit = 1'b1;
          if (writeData == data_q[i] && hit_oh == '0) hit_oh[i] = 1'b1;
        end
      end
    end
  end

  assign wr_hit      = run && memWrite && (hit_oh != '0);
  assign wr_bad      = run && memWrite && addr_hit && (hit_oh == '0);
  assign matched_hit = matched_q | (wr_hit ? hit_oh : '0);
  assign all_matched = ((valid_q & ~matched_hit) == '0);
  assign timed_out   = (cycle_cnt_q == CC_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // A mismatch outranks completion and timeout; completion outranks timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (wr_bad)           state_d = S_FAIL;
        else if (all_matched) state_d = S_PASS;
        else if (timed_out)   state_d = S_FAIL;
      end
      default: begin
        if (start) state_d = (valid_d == '0) ? S_PASS : S_RUN;
      end
    endcase
  end

  // NOTE: every output starts from its held value so no path leaves it unassigned (no latches).
  always_comb begin
    matched_d   = matched_q;
    match_cnt_d = match_cnt_q;
    cycle_cnt_d = cycle_cnt_q;
    err_d       = err_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    if (run) begin
      if (wr_hit) begin
        matched_d   = matched_hit;
        match_cnt_d = match_cnt_q + MC_W'(1);
      end
      case (state_d)
        S_PASS: begin
          done_d = 1'b1;
          pass_d = 1'b1;
        end
        S_FAIL: begin
          done_d = 1'b1;
          fail_d = 1'b1;
          err_d  = wr_bad ? ERR_DATA : ERR_TIMEOUT;
        end
        default: cycle_cnt_d = cycle_cnt_q + CC_W'(1);
      endcase
    end else if (start) begin
      matched_d   = '0;
      match_cnt_d = '0;
      cycle_cnt_d = '0;
      err_d       = ERR_NONE;
      done_d      = (state_d == S_PASS);
      pass_d      = (state_d == S_PASS);
      fail_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      matched_q   <= '0;
      match_cnt_q <= '0;
      cycle_cnt_q <= '0;
      err_q       <= ERR_NONE;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      matched_q   <= matched_d;
      match_cnt_q <= match_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      err_q       <= err_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  // NOTE: the table is reset explicitly because a reset must leave it all-zero, which
  // keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (load_en) begin
      addr_q[exp_idx] <= exp_addr;
      data_q[exp_idx] <= exp_data;
    end
  end

  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign err_code    = err_q;
  assign match_count = match_cnt_q;
  assign cycle_count = cycle_cnt_q;

endmodule
